// File: rtl/teclado_emulador.sv
// 4x4 matrix-keypad emulator: presses a requested key for HOLD_CYC, then enforces a GAP_CYC release.
// Optional contact bounce around each press when TECLADO_REBOTE_EN is defined.
module teclado_emulador #(
  parameter int HOLD_CYC   = 2000,
  parameter int GAP_CYC    = 500,
  parameter int CNT_W      = 16,
  parameter int BOUNCE_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] fila,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       pressed,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYC - 1);
`ifdef TECLADO_REBOTE_EN
  localparam bit REBOTE = 1'b1;
`else
  localparam bit REBOTE = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code;
  logic             contact;

`ifdef TECLADO_REBOTE_EN
  logic [7:0] lfsr;
  logic       bouncing;

  assign bouncing = (state == BOUNCE_IN) || (state == BOUNCE_OUT);
  assign contact  = pressed | (bouncing & lfsr[0]);

  // Fibonacci LFSR, taps 8,6,5,4; only advances while the contact is chattering
  always_ff @(posedge clk) begin
    if (!rst_n)        lfsr <= 8'hA5;
    else if (bouncing) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign contact = pressed;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      code      <= '0;
      pressed   <= 1'b0;
      key_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          key_ready <= 1'b1;
          if (key_valid && key_ready) begin
            code      <= key_code;
            key_ready <= 1'b0;
            if (REBOTE) begin
              state <= BOUNCE_IN;
              cnt   <= BOUNCE_LD;
            end else begin
              state   <= HOLD;
              cnt     <= HOLD_LD;
              pressed <= 1'b1;
            end
          end
        end
        BOUNCE_IN: begin
          if (cnt == '0) begin
            state   <= HOLD;
            cnt     <= HOLD_LD;
            pressed <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        HOLD: begin
          if (cnt == '0) begin
            pressed <= 1'b0;
            if (REBOTE) begin
              state <= BOUNCE_OUT;
              cnt   <= BOUNCE_LD;
            end else begin
              state <= GAP;
              cnt   <= GAP_LD;
            end
          end else cnt <= cnt - 1'b1;
        end
        BOUNCE_OUT: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LD;
          end else cnt <= cnt - 1'b1;
        end
        GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            done      <= 1'b1;
            key_ready <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency row return: only the latched key's row, only when its column is scanned
  always_comb begin
    fila = '0;
    if (contact && col[code[1:0]]) fila[code[3:2]] = 1'b1;
  end

endmodule
